// File: rtl/bft_leaf_pkg.sv
// Shared flit layout and FSM encoding for the BFT leaf driver and its helpers.
package bft_leaf_pkg;

    localparam int FLIT_W    = 49;
    localparam int VALID_BIT = 48;
    localparam int ADDR_LSB  = 43;
    localparam int ADDR_W    = 5;
    localparam int PORT_LSB  = 39;
    localparam int PORT_W    = 4;
    localparam int SEQ_LSB   = 32;
    localparam int SEQ_W     = 7;
    localparam int DATA_W    = 32;
    localparam int WORD_W    = PORT_W + DATA_W;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_START  = 2'd1,
        ST_RUN    = 2'd2,
        ST_RESEND = 2'd3
    } state_e;

    function automatic logic [FLIT_W-1:0] make_flit(
        input logic [ADDR_W-1:0] addr,
        input logic [PORT_W-1:0] port,
        input logic [SEQ_W-1:0]  seq,
        input logic [DATA_W-1:0] data
    );
        return {1'b1, addr, port, seq, data};
    endfunction

endpackage

// File: rtl/leaf_sync_fifo.sv
// Single-clock FIFO with first-word fall-through read data and full/empty flags.
// A push on a full FIFO is still accepted when a pop happens in the same cycle.
module leaf_sync_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/bft_leaf_driver.sv
// Host-side driver for one BFT page leaf: streams TX words out as sequenced flits,
// replays the last flit after an idle timeout, and buffers every received flit.
module bft_leaf_driver
    import bft_leaf_pkg::*;
#(
    parameter logic [ADDR_W-1:0] LEAF_ADDR  = 5'd2,
    parameter int                FIFO_DEPTH = 16,
    parameter int                TIMEOUT    = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] s_data,
    input  logic [PORT_W-1:0] s_port,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [PORT_W-1:0] m_port,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [FLIT_W-1:0] dout_leaf_bft2interface,
    input  logic [FLIT_W-1:0] din_leaf_interface2bft,
    output logic              ap_start,
    output logic              resend,
    output logic              overflow,
    output state_e            dbg_state
);

    localparam int CNT_W = $clog2(TIMEOUT) + 1;

    // Host streams: a word moves on a rising edge where valid && ready; valid must
    // not depend on ready, and ready here depends only on FIFO occupancy.
    logic              tx_full, tx_empty, tx_pop;
    logic [WORD_W-1:0] tx_word;
    logic              rx_full, rx_empty, rx_pop, rx_in_valid;
    logic [WORD_W-1:0] rx_word;
    logic [FLIT_W-1:0] tx_flit;
    logic              unused_din_fields;

    state_e             state_q, state_d;
    logic [SEQ_W-1:0]   seq_q, seq_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               pending_q, pending_d;
    logic               overflow_q, overflow_d;
    logic               ap_start_q, ap_start_d;
    logic               resend_q, resend_d;
    logic [FLIT_W-1:0]  replay_q, replay_d;
    logic [FLIT_W-1:0]  dout_q, dout_d;

    assign s_ready     = !tx_full;
    assign m_valid     = !rx_empty;
    assign rx_pop      = m_valid && m_ready;
    assign rx_in_valid = din_leaf_interface2bft[VALID_BIT];
    assign m_port      = rx_word[WORD_W-1 -: PORT_W];
    assign m_data      = rx_word[DATA_W-1:0];
    assign tx_flit     = make_flit(LEAF_ADDR, tx_word[WORD_W-1 -: PORT_W], seq_q,
                                   tx_word[DATA_W-1:0]);
    assign unused_din_fields = ^{din_leaf_interface2bft[ADDR_LSB +: ADDR_W],
                                 din_leaf_interface2bft[SEQ_LSB +: SEQ_W]};

    leaf_sync_fifo #(.WIDTH(WORD_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (s_valid && s_ready),
        .push_data ({s_port, s_data}),
        .pop       (tx_pop),
        .pop_data  (tx_word),
        .full      (tx_full),
        .empty     (tx_empty)
    );

    // The BFT side is never stalled: the FIFO drops the flit itself when full.
    leaf_sync_fifo #(.WIDTH(WORD_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (rx_in_valid),
        .push_data ({din_leaf_interface2bft[PORT_LSB +: PORT_W],
                     din_leaf_interface2bft[DATA_W-1:0]}),
        .pop       (rx_pop),
        .pop_data  (rx_word),
        .full      (rx_full),
        .empty     (rx_empty)
    );

    always_comb begin
        state_d    = state_q;
        seq_d      = seq_q;
        cnt_d      = cnt_q;
        pending_d  = pending_q;
        replay_d   = replay_q;
        dout_d     = '0;
        tx_pop     = 1'b0;
        overflow_d = overflow_q || (rx_in_valid && rx_full && !rx_pop);

        // Any arriving flit counts as the peer being alive.
        if (rx_in_valid) begin
            cnt_d     = '0;
            pending_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_START;
            end
            ST_START: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!tx_empty) begin
                    tx_pop    = 1'b1;
                    dout_d    = tx_flit;
                    replay_d  = tx_flit;
                    seq_d     = seq_q + 7'd1;
                    pending_d = 1'b1;
                    cnt_d     = '0;
                end else if (pending_q && !rx_in_valid) begin
                    if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        state_d = ST_RESEND;
                        dout_d  = replay_q;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_RESEND: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
            default: state_d = ST_IDLE;
        endcase

        ap_start_d = (state_d == ST_START);
        resend_d   = (state_d == ST_RESEND);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            seq_q      <= '0;
            cnt_q      <= '0;
            pending_q  <= 1'b0;
            overflow_q <= 1'b0;
            ap_start_q <= 1'b0;
            resend_q   <= 1'b0;
            replay_q   <= '0;
            dout_q     <= '0;
        end else begin
            state_q    <= state_d;
            seq_q      <= seq_d;
            cnt_q      <= cnt_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            ap_start_q <= ap_start_d;
            resend_q   <= resend_d;
            replay_q   <= replay_d;
            dout_q     <= dout_d;
        end
    end

    assign dout_leaf_bft2interface = dout_q;
    assign ap_start  = ap_start_q;
    assign resend    = resend_q;
    assign overflow  = overflow_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_bft_leaf_driver.sv
// Self-checking bench for bft_leaf_driver: TX flit table, resend timing,
// RX buffering/overflow, reset discard and sequence wrap.
module tb_bft_leaf_driver;
    import bft_leaf_pkg::*;

    logic        clk, reset, start;
    logic [31:0] s_data;
    logic [3:0]  s_port;
    logic        s_valid, s_ready;
    logic [31:0] m_data;
    logic [3:0]  m_port;
    logic        m_valid, m_ready;
    logic [48:0] dout, din;
    logic        ap_start, resend, overflow;
    state_e      dbg_state;

    bft_leaf_driver dut (
        .clk                     (clk),
        .reset                   (reset),
        .start                   (start),
        .s_data                  (s_data),
        .s_port                  (s_port),
        .s_valid                 (s_valid),
        .s_ready                 (s_ready),
        .m_data                  (m_data),
        .m_port                  (m_port),
        .m_valid                 (m_valid),
        .m_ready                 (m_ready),
        .dout_leaf_bft2interface (dout),
        .din_leaf_interface2bft  (din),
        .ap_start                (ap_start),
        .resend                  (resend),
        .overflow                (overflow),
        .dbg_state               (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // scoreboard state
    logic [48:0] tx_exp_q[$];
    int          tx_cyc_q[$];
    logic [35:0] rx_exp_q[$];
    int          tests = 0, failed = 0;
    int          cyc = 0;
    bit          mon_en = 0;
    logic [6:0]  exp_seq = 0;
    logic [48:0] last_flit = '0;
    int          last_cyc = 0;
    bit          rec_en = 0;
    int          rec_idx = 0;
    logic [6:0]  seen_seq [140];

    typedef struct {
        logic [3:0]  port;
        logic [31:0] data;
        logic [48:0] exp_flit;
    } tx_vec_t;
    tx_vec_t tab [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance to the next falling edge and score whatever the DUT drove on dout.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (mon_en) begin
            if (dout[48]) begin
                if (tx_exp_q.size() == 0) begin
                    tests++;
                    failed++;
                    $display("FAIL tx_unexpected: got flit 0x%0h expected none (cycle %0d)", dout, cyc);
                end else begin
                    check("tx_flit", 64'(dout), 64'(tx_exp_q.pop_front()));
                    check("tx_latency", 64'(cyc), 64'(tx_cyc_q.pop_front()));
                end
                last_flit = dout;
                last_cyc  = cyc;
                if (rec_en && rec_idx < 140) begin
                    seen_seq[rec_idx] = dout[38:32];
                    rec_idx++;
                end
            end else begin
                check("dout_zero_when_idle", 64'(dout), 64'd0);
            end
        end
    endtask

    task automatic push_tx(input logic [3:0] port, input logic [31:0] data);
        s_valid = 1'b1;
        s_port  = port;
        s_data  = data;
        check("s_ready_on_push", 64'(s_ready), 64'd1);
        tx_exp_q.push_back({1'b1, 5'd2, port, exp_seq, data});
        tx_cyc_q.push_back(cyc + 2);
        exp_seq++;
        tick();
        s_valid = 1'b0;
    endtask

    task automatic drain_tx();
        for (int k = 0; k < 40 && tx_exp_q.size() != 0; k++) tick();
        check("tx_drain_left", 64'(tx_exp_q.size()), 64'd0);
        tx_exp_q.delete();
        tx_cyc_q.delete();
    endtask

    task automatic inject_rx(input logic [3:0] port, input logic [31:0] data, input bit expect_kept);
        din = {1'b1, 5'd1, port, 7'd0, data};
        if (expect_kept) rx_exp_q.push_back({port, data});
        tick();
        din = '0;
    endtask

    task automatic drain_rx();
        m_ready = 1'b1;
        for (int k = 0; k < 40 && rx_exp_q.size() != 0; k++) begin
            if (m_valid) check("rx_word", 64'({m_port, m_data}), 64'(rx_exp_q.pop_front()));
            tick();
        end
        m_ready = 1'b0;
        check("rx_drain_left", 64'(rx_exp_q.size()), 64'd0);
        check("rx_empty_after_drain", 64'(m_valid), 64'd0);
        rx_exp_q.delete();
    endtask

    initial begin
        int  f;
        bit  bad;
        tab[0] = '{4'd1,  32'h0000_000A, '0};
        tab[1] = '{4'd1,  32'h0000_000B, '0};
        tab[2] = '{4'd1,  32'h0000_000C, '0};
        tab[3] = '{4'd0,  32'h0000_0000, '0};
        tab[4] = '{4'd15, 32'hFFFF_FFFF, '0};
        tab[5] = '{4'd7,  32'h1234_5678, '0};
        tab[6] = '{4'd8,  32'h8000_0001, '0};
        tab[7] = '{4'd3,  32'hDEAD_BEEF, '0};
        for (int i = 0; i < 8; i++)
            tab[i].exp_flit = {1'b1, 5'd2, tab[i].port, 7'(i), tab[i].data};

        reset = 1'b1; start = 1'b0; s_valid = 1'b0; s_port = '0; s_data = '0;
        m_ready = 1'b0; din = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        mon_en = 1;

        // reset state
        check("rst_dout", 64'(dout), 64'd0);
        check("rst_ap_start", 64'(ap_start), 64'd0);
        check("rst_resend", 64'(resend), 64'd0);
        check("rst_m_valid", 64'(m_valid), 64'd0);
        check("rst_s_ready", 64'(s_ready), 64'd1);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_state", 64'(dbg_state), 64'(ST_IDLE));

        // start pulse
        start = 1'b1;
        check("ap_start_before", 64'(ap_start), 64'd0);
        tick();
        start = 1'b0;
        check("ap_start_pulse", 64'(ap_start), 64'd1);
        check("state_start", 64'(dbg_state), 64'(ST_START));
        tick();
        check("ap_start_drop", 64'(ap_start), 64'd0);
        check("state_run", 64'(dbg_state), 64'(ST_RUN));
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("start_ignored_ap", 64'(ap_start), 64'd0);
        check("start_ignored_state", 64'(dbg_state), 64'(ST_RUN));

        // table-driven TX flits, back to back
        for (int i = 0; i < 8; i++) begin
            s_valid = 1'b1;
            s_port  = tab[i].port;
            s_data  = tab[i].data;
            check("s_ready_on_push", 64'(s_ready), 64'd1);
            tx_exp_q.push_back(tab[i].exp_flit);
            tx_cyc_q.push_back(cyc + 2);
            tick();
        end
        s_valid = 1'b0;
        exp_seq = 7'd8;
        drain_tx();

        // no response: replay exactly 256 cycles after the last flit
        mon_en = 0;
        f = last_cyc;
        bad = 0;
        while (cyc < f + 256) begin
            tick();
            if (cyc < f + 256 && (resend || dout != '0)) bad = 1;
        end
        check("no_early_resend", 64'(bad), 64'd0);
        check("resend_pulse", 64'(resend), 64'd1);
        check("resend_flit", 64'(dout), 64'(tab[7].exp_flit));
        check("resend_state", 64'(dbg_state), 64'(ST_RESEND));
        tick();
        check("resend_drop", 64'(resend), 64'd0);
        check("resend_dout_clear", 64'(dout), 64'd0);
        check("resend_back_run", 64'(dbg_state), 64'(ST_RUN));
        mon_en = 1;

        // response at cycle 255 suppresses the resend
        push_tx(4'd3, 32'h5555_AAAA);
        drain_tx();
        f = last_cyc;
        while (cyc < f + 255) tick();
        din = {1'b1, 5'd0, 4'd9, 7'd0, 32'hACCE_55ED};
        tick();
        din = '0;
        bad = 0;
        for (int k = 0; k < 300; k++) begin
            tick();
            if (resend) bad = 1;
        end
        check("no_resend_after_ack", 64'(bad), 64'd0);
        check("ack_buffered_valid", 64'(m_valid), 64'd1);
        check("ack_buffered_word", 64'({m_port, m_data}), 64'({4'd9, 32'hACCE_55ED}));
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        check("ack_popped", 64'(m_valid), 64'd0);

        // RX: full FIFO with simultaneous push and pop loses nothing
        for (int i = 0; i < 16; i++) inject_rx(4'(i), $urandom(), 1);
        check("rx_full_valid", 64'(m_valid), 64'd1);
        check("rx_full_no_ovf", 64'(overflow), 64'd0);
        check("rx_word", 64'({m_port, m_data}), 64'(rx_exp_q.pop_front()));
        m_ready = 1'b1;
        inject_rx(4'd5, 32'hC0DE_0005, 1);
        m_ready = 1'b0;
        check("rx_pushpop_no_ovf", 64'(overflow), 64'd0);
        drain_rx();

        // RX: 17 arrivals with no consumer, 16 kept
        for (int i = 0; i < 16; i++) inject_rx(4'($urandom_range(0, 15)), $urandom(), 1);
        check("rx_16_no_ovf", 64'(overflow), 64'd0);
        inject_rx(4'd14, 32'hBAD0_0017, 0);
        check("rx_17_ovf", 64'(overflow), 64'd1);
        drain_rx();
        check("ovf_sticky", 64'(overflow), 64'd1);

        // reset with queued work on both sides
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1;
            s_port  = 4'(i);
            s_data  = 32'h7000_0000 + 32'(i);
            check("s_ready_idle_push", 64'(s_ready), 64'd1);
            tick();
        end
        s_valid = 1'b0;
        for (int i = 0; i < 17; i++) inject_rx(4'd2, $urandom(), 0);
        check("pre_rst_ovf", 64'(overflow), 64'd1);
        check("pre_rst_m_valid", 64'(m_valid), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_dout", 64'(dout), 64'd0);
        check("mid_rst_s_ready", 64'(s_ready), 64'd1);
        check("mid_rst_m_valid", 64'(m_valid), 64'd0);
        check("mid_rst_overflow", 64'(overflow), 64'd0);
        check("mid_rst_state", 64'(dbg_state), 64'(ST_IDLE));
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (30) tick();
        check("post_rst_run", 64'(dbg_state), 64'(ST_RUN));

        // sequence wrap over 130 flits
        exp_seq = 7'd0;
        rec_en  = 1;
        rec_idx = 0;
        for (int i = 0; i < 130; i++) push_tx(4'(i % 16), 32'(i * 3 + 1));
        drain_tx();
        rec_en = 0;
        check("wrap_count", 64'(rec_idx), 64'd130);
        check("wrap_seq_127", 64'(seen_seq[127]), 64'd127);
        check("wrap_seq_128", 64'(seen_seq[128]), 64'd0);
        check("wrap_seq_129", 64'(seen_seq[129]), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
